seg7_scan_mux: RTL



---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_hex_decode.sv | 17 +
 rtl/seg7_scan_mux.sv | 115 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the all-off pattern and the active-high hex glyph table.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // All segments dark, active-high sense; pin polarity is applied later.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high {g,f,e,d,c,b,a} glyphs for hex 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble + decimal point to active-high {dp,g..a} pattern.
// Zero latency; no flow control.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o               = SEG_OFF;
    seg_o[SEG_G:SEG_A]  = HEX_SEG[nib_i];
    seg_o[SEG_DP]       = dp_i;
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment scanner with frame-coherent shadow latching and blanking.
// Outputs registered, 1 cycle behind the scan state; free-running, no backpressure.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    frame_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NP = 1 << IW;

  localparam logic [CW-1:0]         CNT_LAST     = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST     = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_POL      = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_POL      = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
  logic                    load_init_q, load_init_d;
  logic                    frame_q, frame_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic                    slot_end;
  logic                    load;
  logic                    lit;
  logic [4*NP-1:0]         data_pad;
  logic [NP-1:0]           dp_pad;
  logic [NP-1:0]           en_pad;
  logic [NP-1:0]           hot_pad;
  logic [3:0]              cur_nib;
  logic [7:0]              cur_pat;

  // Padding to a power of two lets idx_q index directly for any digit count.
  always_comb begin
    data_pad = (4*NP)'(data_sh_q);
    dp_pad   = NP'(dp_sh_q);
    en_pad   = NP'(en_sh_q);
    cur_nib  = data_pad[{idx_q, 2'b00} +: 4];
    hot_pad  = '0;
    hot_pad[idx_q] = 1'b1;
  end

  seg7_hex_decode u_dec (
    .nib_i (cur_nib),
    .dp_i  (dp_pad[idx_q]),
    .seg_o (cur_pat)
  );

  always_comb begin
    slot_end    = (cnt_q == CNT_LAST);
    cnt_d       = slot_end ? '0 : cnt_q + CW'(1);
    idx_d       = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    load        = load_init_q | (slot_end & (idx_q == IDX_LAST));
    load_init_d = 1'b0;
    frame_d     = load;
    data_sh_d   = load ? data_i : data_sh_q;
    dp_sh_d     = load ? dp_i   : dp_sh_q;
    en_sh_d     = load ? en_i   : en_sh_q;

    lit   = (int'(cnt_q) >= BLANK_CYCLES) & en_pad[idx_q];
    seg_d = (lit ? cur_pat : SEG_OFF) ^ SEG_POL;
    sel_d = (lit ? hot_pad[NUM_DIGITS-1:0] : '0) ^ SEL_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      data_sh_q   <= '0;
      dp_sh_q     <= '0;
      en_sh_q     <= '0;
      load_init_q <= 1'b1;
      frame_q     <= 1'b0;
      seg_q       <= SEG_OFF ^ SEG_POL;
      sel_q       <= SEL_POL;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_sh_q   <= data_sh_d;
      dp_sh_q     <= dp_sh_d;
      en_sh_q     <= en_sh_d;
      load_init_q <= load_init_d;
      frame_q     <= frame_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign seg     = seg_q;
  assign sel     = sel_q;
  assign frame_o = frame_q;

endmodule
